post_adder_alu: RTL and testbench

- Final arithmetic stage of the DSP slice, directly downstream of the carry-in select logic.
- Consumes its CIN together with the X/Y/Z multiplexer outputs and computes a 48-bit add/subtract or bitwise logic result under ALUMODE control.
- Registers the result as P, with carry-out and cascade outputs.
- P[47] and PCOUT feed back to the carry-in select logic and to the neighbouring slice.

---
 rtl/post_adder_alu.sv | 108 ++++++++++
 tb/tb_post_adder_alu.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/post_adder_alu.sv
// Final DSP-slice stage: 48-bit add/subtract or bitwise logic under ALUMODE, registered as P.
// Optional masked pattern compare on the result is built only when PATTERN_DETECT_EN is defined.
module post_adder_alu #(
  parameter int          ALUMODEREG = 1,
  parameter int          PREG       = 1,
  parameter logic [47:0] PATTERN    = 48'h0,
  parameter logic [47:0] MASK       = 48'h3FFF_FFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RSTP,
  input  logic        CEP,
  input  logic        CEALUMODE,
  input  logic        CIN,
  input  logic [3:0]  ALUMODE,
  input  logic [47:0] X,
  input  logic [47:0] Y,
  input  logic [47:0] Z,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYCASCOUT,
  output logic        PATTERNDETECT,
  output logic        PATTERNBDETECT
);

  logic [3:0]  alumode_reg;
  logic [3:0]  am;
  logic [47:0] zi;
  logic [49:0] sum;
  logic        sum_unused;
  logic [47:0] r;
  logic        co;
  logic        pd;
  logic        pbd;
  logic [47:0] p_reg;
  logic        co_reg;
  logic        pd_reg;
  logic        pbd_reg;

  // ALUMODE pipeline register
  always_ff @(posedge CLK or posedge RSTP) begin
    if (RSTP) begin
      alumode_reg <= 4'b0000;
    end else if (CEALUMODE) begin
      alumode_reg <= ALUMODE;
    end
  end

  assign am = (ALUMODEREG != 0) ? alumode_reg : ALUMODE;

  // Inverting Z and/or the sum gives all four add/subtract flavours from one adder
  assign zi         = am[0] ? ~Z : Z;
  assign sum        = {2'b00, zi} + {2'b00, X} + {2'b00, Y} + {49'h0, CIN};
  assign sum_unused = sum[49];

  // Operation select; undefined codes produce a defined zero result
  always_comb begin
    r  = 48'h0;
    co = 1'b0;
    case (am)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        r  = am[1] ? ~sum[47:0] : sum[47:0];
        co = sum[48] ^ am[1];
      end
      4'b0100: r = X ^ Z;
      4'b0101: r = ~(X ^ Z);
      4'b1100: r = X & Z;
      4'b1110: r = X | Z;
      default: begin
        r  = 48'h0;
        co = 1'b0;
      end
    endcase
  end

`ifdef PATTERN_DETECT_EN
  assign pd  = &((r ~^ PATTERN) | MASK);
  assign pbd = &((r ~^ ~PATTERN) | MASK);
`else
  logic [47:0] pattern_unused;
  assign pattern_unused = PATTERN ^ MASK;
  assign pd  = 1'b0;
  assign pbd = 1'b0;
`endif

  // P-stage registers
  always_ff @(posedge CLK or posedge RSTP) begin
    if (RSTP) begin
      p_reg   <= 48'h0;
      co_reg  <= 1'b0;
      pd_reg  <= 1'b0;
      pbd_reg <= 1'b0;
    end else if (CEP) begin
      p_reg   <= r;
      co_reg  <= co;
      pd_reg  <= pd;
      pbd_reg <= pbd;
    end
  end

  assign P              = (PREG != 0) ? p_reg   : r;
  assign CARRYOUT       = (PREG != 0) ? co_reg  : co;
  assign PATTERNDETECT  = (PREG != 0) ? pd_reg  : pd;
  assign PATTERNBDETECT = (PREG != 0) ? pbd_reg : pbd;
  assign PCOUT          = P;
  assign CARRYCASCOUT   = CARRYOUT;

endmodule

// File: tb/tb_post_adder_alu.sv
// Directed self-checking bench for post_adder_alu with ALUMODEREG=1 and PREG=1.
module tb_post_adder_alu;

  logic        CLK = 1'b0;
  logic        RSTP;
  logic        CEP;
  logic        CEALUMODE;
  logic        CIN;
  logic [3:0]  ALUMODE;
  logic [47:0] X;
  logic [47:0] Y;
  logic [47:0] Z;
  logic [47:0] P;
  logic [47:0] PCOUT;
  logic        CARRYOUT;
  logic        CARRYCASCOUT;
  logic        PATTERNDETECT;
  logic        PATTERNBDETECT;

  int checks   = 0;
  int failures = 0;
  logic exp_pd;

  post_adder_alu #(
    .ALUMODEREG(1),
    .PREG(1),
    .PATTERN(48'h100),
    .MASK(48'h3FFF_FFFF_FFFF)
  ) dut (
    .CLK(CLK),
    .RSTP(RSTP),
    .CEP(CEP),
    .CEALUMODE(CEALUMODE),
    .CIN(CIN),
    .ALUMODE(ALUMODE),
    .X(X),
    .Y(Y),
    .Z(Z),
    .P(P),
    .PCOUT(PCOUT),
    .CARRYOUT(CARRYOUT),
    .CARRYCASCOUT(CARRYCASCOUT),
    .PATTERNDETECT(PATTERNDETECT),
    .PATTERNBDETECT(PATTERNBDETECT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_mode(input logic [3:0] m);
    ALUMODE   = m;
    CEALUMODE = 1'b1;
    tick();
    CEALUMODE = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] m, input logic [47:0] x, input logic [47:0] y,
                        input logic [47:0] z, input logic c);
    load_mode(m);
    X = x; Y = y; Z = z; CIN = c;
    tick();
  endtask

  initial begin
    RSTP = 1'b1; CEP = 1'b0; CEALUMODE = 1'b0; CIN = 1'b0;
    ALUMODE = 4'b0000; X = 48'h0; Y = 48'h0; Z = 48'h0;
`ifdef PATTERN_DETECT_EN
    exp_pd = 1'b1;
`else
    exp_pd = 1'b0;
`endif
    #12;
    check("rst_p", P, 48'h0);
    check("rst_pcout", PCOUT, 48'h0);
    check("rst_co", {47'h0, CARRYOUT}, 48'h0);
    check("rst_pd", {46'h0, PATTERNDETECT, PATTERNBDETECT}, 48'h0);
    @(negedge CLK);
    RSTP = 1'b0; CEP = 1'b1;

    run_op(4'b0000, 48'h1, 48'h0, 48'hFFFF_FFFF_FFFF, 1'b0);
    check("add_wrap_p", P, 48'h0);
    check("add_wrap_pcout", PCOUT, 48'h0);
    check("add_wrap_co", {46'h0, CARRYOUT, CARRYCASCOUT}, 48'h3);

    run_op(4'b0011, 48'd3, 48'd2, 48'd10, 1'b1);
    check("sub_p", P, 48'd4);
    check("sub_co", {47'h0, CARRYOUT}, 48'h1);
    run_op(4'b0011, 48'd5, 48'd0, 48'd3, 1'b0);
    check("sub_neg_p", P, 48'hFFFF_FFFF_FFFE);
    check("sub_neg_co", {47'h0, CARRYOUT}, 48'h0);

    run_op(4'b0001, 48'd10, 48'd0, 48'd5, 1'b0);
    check("m0001_p", P, 48'd4);
    check("m0001_co", {47'h0, CARRYOUT}, 48'h1);
    run_op(4'b0010, 48'd2, 48'd3, 48'd1, 1'b0);
    check("m0010_p", P, 48'hFFFF_FFFF_FFF9);

    run_op(4'b1100, 48'hF0F0, 48'h5, 48'hFF00, 1'b1);
    check("and_p", P, 48'hF000);
    check("and_co", {47'h0, CARRYOUT}, 48'h0);
    run_op(4'b0100, 48'hF0F0, 48'h0, 48'hFF00, 1'b0);
    check("xor_p", P, 48'h0FF0);
    run_op(4'b0101, 48'hF0F0, 48'h0, 48'hFF00, 1'b0);
    check("xnor_p", P, 48'hFFFF_FFFF_F00F);
    run_op(4'b1110, 48'hF0F0, 48'h0, 48'hFF00, 1'b0);
    check("or_p", P, 48'hFFF0);
    run_op(4'b1111, 48'hF0F0, 48'h0, 48'hFF00, 1'b0);
    check("undef_p", P, 48'h0);

    CEP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_mode(4'b0000);
      X = 48'h1000 + 48'(i);
    end
    tick();
    check("cep_hold_p", P, 48'h0);
    CEP = 1'b1;

    X = 48'd3; Y = 48'd2; Z = 48'd10; CIN = 1'b1;
    ALUMODE = 4'b0011; CEALUMODE = 1'b1;
    tick();
    CEALUMODE = 1'b0;
    check("modelat_edge1", P, 48'd16);
    tick();
    check("modelat_edge2", P, 48'd4);

    run_op(4'b0000, 48'hFF, 48'h0, 48'h0, 1'b1);
    check("pat_p", P, 48'h100);
    check("pat_pd", {47'h0, PATTERNDETECT}, {47'h0, exp_pd});
    check("pat_pbd", {47'h0, PATTERNBDETECT}, 48'h0);

    run_op(4'b0000, 48'h1234, 48'h0, 48'h0, 1'b0);
    check("pre_rst_p", P, 48'h1234);
    #2;
    RSTP = 1'b1;
    #1;
    check("async_rst_p", P, 48'h0);
    check("async_rst_co", {46'h0, CARRYOUT, CARRYCASCOUT}, 48'h0);
    check("async_rst_pd", {46'h0, PATTERNDETECT, PATTERNBDETECT}, 48'h0);
    @(negedge CLK);
    RSTP = 1'b0;
    ALUMODE = 4'b0011;
    tick();
    check("post_rst_mode", P, 48'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=%0d exp=0", checks);
    $fatal(1, "timeout");
  end

endmodule
